// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS voice.
//   wave_t  : waveform select encoding (matches the wave_sel input)
//   state_t : generator FSM states
//   SAMPLE_MAX / SAMPLE_MIN : signed 16-bit full-scale limits
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SILENT = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   push_i, wdata_i  : write request/data (ignored when full)
//   ready_i          : downstream accepts data_o this cycle
//   data_o, valid_o  : registered head entry and non-empty flag
//   level_o          : current occupancy (0..DEPTH)
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             pop, push_ok;

  assign pop     = valid_q & ready_i;
  assign push_ok = push_i & (count_q != LVL_W'(DEPTH));

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    count_d  = count_q + LVL_W'(push_ok) - LVL_W'(pop);
    valid_d  = (count_d != '0);
    data_d   = data_q;
    // The head register is loaded one edge early: if the queue is otherwise
    // empty the incoming word becomes the head, else the entry under the
    // advanced read pointer (already in memory) does. Data holds when empty.
    if (count_d != '0) begin
      if ((count_q - LVL_W'(pop)) == '0) data_d = wdata_i;
      else                               data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign level_o = count_q;

endmodule

// File: rtl/dds_voice.sv
// Single-voice DDS sample generator feeding a small output FIFO.
//   mclk_i, rst_i          : master clock, asynchronous active-high reset
//   enable_i               : generator runs while high
//   tune_word_i            : phase increment per generated sample
//   wave_sel_i             : 0 square, 1 saw, 2 triangle, 3 silence
//   volume_i               : arithmetic right-shift applied to the sample
//   sample_data_o/valid_o  : registered FIFO head, valid/ready handshake
//   sample_ready_i         : downstream pop
//   fifo_level_o           : FIFO occupancy
// Build option: DDS_TRIANGLE_EN enables the triangle wave; without it
// wave_sel=2 yields silence.
module dds_voice
  import dds_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int PHASE_BITS  = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int VOLUME_BITS = 4,
  parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          mclk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [PHASE_BITS-1:0]         tune_word_i,
  input  logic [1:0]                    wave_sel_i,
  input  logic [VOLUME_BITS-1:0]        volume_i,
  output logic signed [SAMPLE_BITS-1:0] sample_data_o,
  output logic                          sample_valid_o,
  input  logic                          sample_ready_i,
  output logic [LVL_W-1:0]              fifo_level_o
);

  state_t                        state_q, state_d;
  logic [PHASE_BITS-1:0]         phase_q, tune_q;
  logic signed [SAMPLE_BITS-1:0] sample_q, raw, shaped;
  logic                          push, pop, full_after;
  logic [SAMPLE_BITS-1:0]        fifo_dout;
`ifdef DDS_TRIANGLE_EN
  logic [14:0]                   tri_x;
`endif

  assign push = (state_q == ST_PUSH);
  assign pop  = sample_valid_o & sample_ready_i;
  // A push from PUSH always finds room (CALC was entered below full and
  // nothing was written since), so the level after this edge is level+1-pop.
  assign full_after = (fifo_level_o == LVL_W'(FIFO_DEPTH - 1)) && !pop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable_i && fifo_level_o < LVL_W'(FIFO_DEPTH)) state_d = ST_CALC;
      ST_CALC: state_d = ST_PUSH;
      ST_PUSH: state_d = (enable_i && !full_after) ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Waveform shaping from the current phase, evaluated during CALC.
  always_comb begin
    raw = '0;
`ifdef DDS_TRIANGLE_EN
    tri_x = phase_q[PHASE_BITS-2 -: 15];
    if (phase_q[PHASE_BITS-1]) tri_x = ~tri_x;
`endif
    case (wave_t'(wave_sel_i))
      WAVE_SQUARE: raw = phase_q[PHASE_BITS-1] ? SAMPLE_MIN : SAMPLE_MAX;
      WAVE_SAW:    raw = phase_q[PHASE_BITS-1 -: 16] ^ 16'h8000;
`ifdef DDS_TRIANGLE_EN
      WAVE_TRI:    raw = {tri_x, 1'b0} ^ 16'h8000;
`endif
      default:     raw = '0;
    endcase
    shaped = raw >>> volume_i;
  end

  // wave_sel and volume are consumed into sample_q at CALC, so only the
  // tune word needs its own register to be applied at PUSH.
  always_ff @(posedge mclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      tune_q   <= '0;
      sample_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CALC) begin
        sample_q <= shaped;
        tune_q   <= tune_word_i;
      end
      if (push && fifo_level_o != LVL_W'(FIFO_DEPTH)) phase_q <= phase_q + tune_q;
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_BITS),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (mclk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (sample_q),
    .ready_i (sample_ready_i),
    .data_o  (fifo_dout),
    .valid_o (sample_valid_o),
    .level_o (fifo_level_o)
  );

  assign sample_data_o = $signed(fifo_dout);

endmodule

// File: tb/tb_dds_voice.sv
module tb_dds_voice;
  import dds_pkg::*;

  logic               mclk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic [23:0]        tune_word = 24'h400000;
  logic [1:0]         wave_sel = 2'd0;
  logic [3:0]         volume = 4'd0;
  logic signed [15:0] sample_data;
  logic               sample_valid;
  logic               sample_ready = 1'b0;
  logic [2:0]         fifo_level;

  int n_chk  = 0;
  int n_pass = 0;
  int samp [16];

  always #5 mclk = ~mclk;

  dds_voice dut (
    .mclk_i         (mclk),
    .rst_i          (rst),
    .enable_i       (enable),
    .tune_word_i    (tune_word),
    .wave_sel_i     (wave_sel),
    .volume_i       (volume),
    .sample_data_o  (sample_data),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .fifo_level_o   (fifo_level)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge mclk);
    rst = 1'b1;
    repeat (2) @(negedge mclk);
    rst = 1'b0;
  endtask

  // Records n popped samples (ready must be high); starts at a negedge.
  task automatic collect(input int n);
    int k = 0;
    int budget = n * 4 + 20;
    while (k < n && budget > 0) begin
      if (sample_valid) begin
        samp[k] = int'(sample_data);
        k++;
      end
      @(negedge mclk);
      budget--;
    end
    if (k < n) chk("collect_timeout", k, n);
  endtask

  task automatic run_case(input string tag, input logic [1:0] w, input logic [3:0] v,
                          input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    enable = 1'b0;
    sample_ready = 1'b1;
    wave_sel = w;
    volume = v;
    do_reset();
    enable = 1'b1;
    collect(8);
    for (int k = 0; k < 8; k++) chk($sformatf("%s[%0d]", tag, k), samp[k], e[k % 4]);
  endtask

  initial begin
    int sq [4];
    int saw [4];
    int lv;
    sq  = '{32767, 32767, -32768, -32768};
    saw = '{-32768, -16384, 0, 16384};

    // Reset state
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_data", int'(sample_data), 0);

    // Latency: enable -> valid three edges later, first sample at phase 0
    sample_ready = 1'b1;
    enable = 1'b1;
    @(negedge mclk);
    chk("lat_e1", int'(sample_valid), 0);
    @(negedge mclk);
    chk("lat_e2", int'(sample_valid), 0);
    @(negedge mclk);
    chk("lat_e3", int'(sample_valid), 1);
    chk("lat_data", int'(sample_data), 32767);
    @(negedge mclk);
    collect(7);
    for (int k = 0; k < 7; k++) chk($sformatf("square[%0d]", k + 1), samp[k], sq[(k + 1) % 4]);

    run_case("saw", 2'd1, 4'd0, -32768, -16384, 0, 16384);
`ifdef DDS_TRIANGLE_EN
    run_case("tri", 2'd2, 4'd0, -32768, 0, 32766, -2);
`else
    run_case("tri", 2'd2, 4'd0, 0, 0, 0, 0);
`endif
    run_case("sq_vol2", 2'd0, 4'd2, 8191, 8191, -8192, -8192);
    run_case("silent", 2'd3, 4'd0, 0, 0, 0, 0);

    // Backpressure: fills to depth, FSM parks in IDLE, head stays stable
    enable = 1'b0;
    sample_ready = 1'b0;
    wave_sel = 2'd1;
    volume = 4'd0;
    do_reset();
    enable = 1'b1;
    repeat (20) @(negedge mclk);
    chk("bp_level", int'(fifo_level), 4);
    chk("bp_state", int'(dut.state_q), int'(ST_IDLE));
    chk("bp_valid", int'(sample_valid), 1);
    chk("bp_data", int'(sample_data), -32768);
    sample_ready = 1'b1;
    collect(10);
    for (int k = 0; k < 10; k++) chk($sformatf("bp_seq[%0d]", k), samp[k], saw[k % 4]);

    // Asynchronous reset mid-stream with three samples buffered
    enable = 1'b0;
    sample_ready = 1'b0;
    wave_sel = 2'd0;
    do_reset();
    enable = 1'b1;
    lv = 0;
    for (int c = 0; c < 50 && fifo_level != 3'd3; c++) @(negedge mclk);
    chk("mid_level3", int'(fifo_level), 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(sample_valid), 0);
    chk("mid_rst_level", int'(fifo_level), 0);
    @(negedge mclk);
    rst = 1'b0;
    sample_ready = 1'b1;
    collect(1);
    chk("mid_first", samp[0], 32767);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
